// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction, writeback bypass and redirect in;
// registered EX payload, load-use stall and performance counters out.
//   slave  : the id_ex_stage pipeline register
//   master : the decode/writeback side driving it
interface id_ex_stage_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 32
);
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned ALUOP_W   = 2;

   // decode side
   logic                 id_valid;
   logic [REG_IDX_W-1:0] rs1;
   logic [REG_IDX_W-1:0] rs2;
   logic [REG_IDX_W-1:0] rd;
   logic [DATA_W-1:0]    ReadData1;
   logic [DATA_W-1:0]    ReadData2;
   logic [DATA_W-1:0]    imm;
   logic [DATA_W-1:0]    pc;
   logic                 regwrite_in;
   logic                 memread_in;
   logic                 memwrite_in;
   logic                 memtoreg_in;
   logic                 alusrc_in;
   logic                 branch_in;
   logic [ALUOP_W-1:0]   aluop_in;

   // writeback port and redirect
   logic                 wb_regwrite;
   logic [REG_IDX_W-1:0] wb_rd;
   logic [DATA_W-1:0]    wb_data;
   logic                 flush;

   // EX side
   logic                 ex_valid;
   logic [REG_IDX_W-1:0] ex_rs1;
   logic [REG_IDX_W-1:0] ex_rs2;
   logic [REG_IDX_W-1:0] ex_rd;
   logic [DATA_W-1:0]    ex_data1;
   logic [DATA_W-1:0]    ex_data2;
   logic [DATA_W-1:0]    ex_imm;
   logic [DATA_W-1:0]    ex_pc;
   logic                 ex_regwrite;
   logic                 ex_memread;
   logic                 ex_memwrite;
   logic                 ex_memtoreg;
   logic                 ex_alusrc;
   logic                 ex_branch;
   logic [ALUOP_W-1:0]   ex_aluop;
   logic                 stall;
   logic [CNT_W-1:0]     stall_count;
   logic [CNT_W-1:0]     flush_count;

   modport slave (
      input  id_valid, rs1, rs2, rd, ReadData1, ReadData2, imm, pc,
             regwrite_in, memread_in, memwrite_in, memtoreg_in, alusrc_in,
             branch_in, aluop_in, wb_regwrite, wb_rd, wb_data, flush,
      output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2, ex_imm,
             ex_pc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
             ex_alusrc, ex_branch, ex_aluop, stall, stall_count, flush_count
   );

   modport master (
      output id_valid, rs1, rs2, rd, ReadData1, ReadData2, imm, pc,
             regwrite_in, memread_in, memwrite_in, memtoreg_in, alusrc_in,
             branch_in, aluop_in, wb_regwrite, wb_rd, wb_data, flush,
      input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2, ex_imm,
             ex_pc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
             ex_alusrc, ex_branch, ex_aluop, stall, stall_count, flush_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB-to-ID operand
// bypass and saturating stall/flush event counters. One cycle latency.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low clear of all state
//   bus   : id_ex_stage_if.slave (decode/writeback in, EX payload out,
//           combinational stall, stall_count/flush_count)
module id_ex_stage #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 32
) (
   input  logic          clock,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned ALUOP_W   = 2;

   logic                 r_valid;
   logic [REG_IDX_W-1:0] r_rs1;
   logic [REG_IDX_W-1:0] r_rs2;
   logic [REG_IDX_W-1:0] r_rd;
   logic [DATA_W-1:0]    r_data1;
   logic [DATA_W-1:0]    r_data2;
   logic [DATA_W-1:0]    r_imm;
   logic [DATA_W-1:0]    r_pc;
   logic                 r_regwrite;
   logic                 r_memread;
   logic                 r_memwrite;
   logic                 r_memtoreg;
   logic                 r_alusrc;
   logic                 r_branch;
   logic [ALUOP_W-1:0]   r_aluop;
   logic [CNT_W-1:0]     r_stall_cnt;
   logic [CNT_W-1:0]     r_flush_cnt;

   logic                 w_stall;
   logic                 w_byp1;
   logic                 w_byp2;
   logic [DATA_W-1:0]    w_data1;
   logic [DATA_W-1:0]    w_data2;
   logic                 w_bubble;

   // Load in EX whose destination is read by the valid instruction in ID.
   assign w_stall = r_valid & r_memread & (r_rd != '0) & bus.id_valid &
                    ((r_rd == bus.rs1) | (r_rd == bus.rs2));

   // Register file is written this cycle; forward the value being written.
   assign w_byp1  = bus.wb_regwrite & (bus.wb_rd != '0) & (bus.wb_rd == bus.rs1);
   assign w_byp2  = bus.wb_regwrite & (bus.wb_rd != '0) & (bus.wb_rd == bus.rs2);
   assign w_data1 = w_byp1 ? bus.wb_data : bus.ReadData1;
   assign w_data2 = w_byp2 ? bus.wb_data : bus.ReadData2;

   assign w_bubble = bus.flush | w_stall;

   // Pipeline register: flush/stall insert a bubble, else capture ID.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_valid    <= 1'b0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_data1    <= '0;
         r_data2    <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_alusrc   <= 1'b0;
         r_branch   <= 1'b0;
         r_aluop    <= '0;
      end else if (w_bubble) begin
         r_valid    <= 1'b0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_data1    <= '0;
         r_data2    <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_memtoreg <= 1'b0;
         r_alusrc   <= 1'b0;
         r_branch   <= 1'b0;
         r_aluop    <= '0;
      end else begin
         r_valid    <= bus.id_valid;
         r_rs1      <= bus.rs1;
         r_rs2      <= bus.rs2;
         r_rd       <= bus.rd;
         r_data1    <= w_data1;
         r_data2    <= w_data2;
         r_imm      <= bus.imm;
         r_pc       <= bus.pc;
         // control is qualified so an invalid slot can never write state
         r_regwrite <= bus.id_valid & bus.regwrite_in;
         r_memread  <= bus.id_valid & bus.memread_in;
         r_memwrite <= bus.id_valid & bus.memwrite_in;
         r_memtoreg <= bus.id_valid & bus.memtoreg_in;
         r_alusrc   <= bus.id_valid & bus.alusrc_in;
         r_branch   <= bus.id_valid & bus.branch_in;
         r_aluop    <= bus.id_valid ? bus.aluop_in : '0;
      end
   end

   // Saturating event counters; a simultaneous flush and stall is a flush.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (bus.flush) begin
         if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_stall) begin
         if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign bus.ex_valid    = r_valid;
   assign bus.ex_rs1      = r_rs1;
   assign bus.ex_rs2      = r_rs2;
   assign bus.ex_rd       = r_rd;
   assign bus.ex_data1    = r_data1;
   assign bus.ex_data2    = r_data2;
   assign bus.ex_imm      = r_imm;
   assign bus.ex_pc       = r_pc;
   assign bus.ex_regwrite = r_regwrite;
   assign bus.ex_memread  = r_memread;
   assign bus.ex_memwrite = r_memwrite;
   assign bus.ex_memtoreg = r_memtoreg;
   assign bus.ex_alusrc   = r_alusrc;
   assign bus.ex_branch   = r_branch;
   assign bus.ex_aluop    = r_aluop;
   assign bus.stall       = w_stall;
   assign bus.stall_count = r_stall_cnt;
   assign bus.flush_count = r_flush_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 64-bit instance for function and reset,
// and a CNT_W=4 instance for counter saturation.
module tb_id_ex_stage;
   logic clock;
   logic reset;

   int unsigned n_vec;
   int unsigned n_err;

   id_ex_stage_if #(.DATA_W(64), .CNT_W(32)) bus  ();
   id_ex_stage_if #(.DATA_W(64), .CNT_W(4))  bus2 ();

   id_ex_stage #(.DATA_W(64), .CNT_W(32)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   id_ex_stage #(.DATA_W(64), .CNT_W(4)) u_dut_sat (
      .clock (clock),
      .reset (reset),
      .bus   (bus2.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.id_valid = 1'b0;  bus.rs1 = '0;  bus.rs2 = '0;  bus.rd = '0;
      bus.ReadData1 = '0;   bus.ReadData2 = '0;
      bus.imm = '0;         bus.pc = '0;
      bus.regwrite_in = 1'b0; bus.memread_in = 1'b0; bus.memwrite_in = 1'b0;
      bus.memtoreg_in = 1'b0; bus.alusrc_in = 1'b0;  bus.branch_in = 1'b0;
      bus.aluop_in = '0;
      bus.wb_regwrite = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
      bus.flush = 1'b0;
   endtask

   task automatic clear_inputs2();
      bus2.id_valid = 1'b0;  bus2.rs1 = '0;  bus2.rs2 = '0;  bus2.rd = '0;
      bus2.ReadData1 = '0;   bus2.ReadData2 = '0;
      bus2.imm = '0;         bus2.pc = '0;
      bus2.regwrite_in = 1'b0; bus2.memread_in = 1'b0; bus2.memwrite_in = 1'b0;
      bus2.memtoreg_in = 1'b0; bus2.alusrc_in = 1'b0;  bus2.branch_in = 1'b0;
      bus2.aluop_in = '0;
      bus2.wb_regwrite = 1'b0; bus2.wb_rd = '0; bus2.wb_data = '0;
      bus2.flush = 1'b0;
   endtask

   // Drive a valid load instruction into ID (rd = dst).
   task automatic drive_load(input logic [4:0] dst);
      clear_inputs();
      bus.id_valid = 1'b1; bus.rs1 = 5'd1; bus.rs2 = 5'd2; bus.rd = dst;
      bus.memread_in = 1'b1; bus.memtoreg_in = 1'b1; bus.regwrite_in = 1'b1;
      bus.alusrc_in = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      clear_inputs();
      clear_inputs2();

      // reset state
      #1;
      check_val("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
      check_val("rst_stall",    64'(bus.stall), 64'd0);
      check_val("rst_stall_cnt", 64'(bus.stall_count), 64'd0);
      check_val("rst_flush_cnt", 64'(bus.flush_count), 64'd0);
      #12 reset = 1'b1;

      // normal flow
      bus.id_valid = 1'b1; bus.rs1 = 5'd5; bus.rs2 = 5'd7; bus.rd = 5'd3;
      bus.ReadData1 = 64'd5; bus.ReadData2 = 64'd7; bus.imm = 64'd16;
      bus.pc = 64'h100; bus.regwrite_in = 1'b1; bus.aluop_in = 2'd2;
      tick();
      check_val("nrm_valid",    64'(bus.ex_valid), 64'd1);
      check_val("nrm_data1",    bus.ex_data1, 64'd5);
      check_val("nrm_data2",    bus.ex_data2, 64'd7);
      check_val("nrm_imm",      bus.ex_imm, 64'd16);
      check_val("nrm_pc",       bus.ex_pc, 64'h100);
      check_val("nrm_rd",       64'(bus.ex_rd), 64'd3);
      check_val("nrm_regwrite", 64'(bus.ex_regwrite), 64'd1);
      check_val("nrm_aluop",    64'(bus.ex_aluop), 64'd2);
      check_val("nrm_stall",    64'(bus.stall), 64'd0);

      // load-use hazard on rs2
      drive_load(5'd10);
      tick();
      check_val("ld_memread", 64'(bus.ex_memread), 64'd1);
      clear_inputs();
      bus.id_valid = 1'b1; bus.rs1 = 5'd3; bus.rs2 = 5'd10; bus.rd = 5'd4;
      bus.ReadData1 = 64'h33; bus.ReadData2 = 64'hAA; bus.regwrite_in = 1'b1;
      #1;
      check_val("lu_stall_on", 64'(bus.stall), 64'd1);
      tick();
      check_val("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
      check_val("lu_bubble_rw",    64'(bus.ex_regwrite), 64'd0);
      check_val("lu_bubble_rd",    64'(bus.ex_rd), 64'd0);
      check_val("lu_stall_cnt",    64'(bus.stall_count), 64'd1);
      check_val("lu_stall_off",    64'(bus.stall), 64'd0);
      tick();
      check_val("lu_cap_valid", 64'(bus.ex_valid), 64'd1);
      check_val("lu_cap_rd",    64'(bus.ex_rd), 64'd4);
      check_val("lu_cap_rs2",   64'(bus.ex_rs2), 64'd10);
      check_val("lu_cap_data2", bus.ex_data2, 64'hAA);
      check_val("lu_cnt_hold",  64'(bus.stall_count), 64'd1);

      // load into x0 never stalls
      drive_load(5'd0);
      tick();
      clear_inputs();
      bus.id_valid = 1'b1; bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rd = 5'd6;
      #1;
      check_val("x0_no_stall", 64'(bus.stall), 64'd0);

      // bypass both operands
      clear_inputs();
      bus.id_valid = 1'b1; bus.rs1 = 5'd11; bus.rs2 = 5'd11; bus.rd = 5'd12;
      bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd11; bus.wb_data = 64'd19;
      tick();
      check_val("byp_both_d1", bus.ex_data1, 64'd19);
      check_val("byp_both_d2", bus.ex_data2, 64'd19);

      // wb to x0 must not forward
      bus.wb_rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd11;
      bus.ReadData1 = 64'hAA; bus.ReadData2 = 64'hBB;
      tick();
      check_val("byp_x0_d1", bus.ex_data1, 64'hAA);
      check_val("byp_x0_d2", bus.ex_data2, 64'hBB);

      // rs1 only; wb_regwrite off gives no bypass
      bus.wb_rd = 5'd11; bus.rs1 = 5'd11; bus.rs2 = 5'd12;
      bus.ReadData1 = 64'h1; bus.ReadData2 = 64'hCC;
      tick();
      check_val("byp_rs1_d1", bus.ex_data1, 64'd19);
      check_val("byp_rs1_d2", bus.ex_data2, 64'hCC);
      bus.wb_regwrite = 1'b0;
      tick();
      check_val("byp_nowe_d1", bus.ex_data1, 64'h1);

      // flush over stall
      drive_load(5'd10);
      tick();
      clear_inputs();
      bus.id_valid = 1'b1; bus.rs1 = 5'd10; bus.rd = 5'd9; bus.flush = 1'b1;
      bus.regwrite_in = 1'b1;
      #1;
      check_val("fs_stall_on", 64'(bus.stall), 64'd1);
      tick();
      check_val("fs_valid",     64'(bus.ex_valid), 64'd0);
      check_val("fs_flush_cnt", 64'(bus.flush_count), 64'd1);
      check_val("fs_stall_cnt", 64'(bus.stall_count), 64'd1);
      bus.flush = 1'b0;

      // id_valid=0 loads control as zero
      clear_inputs();
      bus.rd = 5'd7; bus.regwrite_in = 1'b1; bus.memwrite_in = 1'b1;
      bus.aluop_in = 2'd3;
      tick();
      check_val("inv_valid", 64'(bus.ex_valid), 64'd0);
      check_val("inv_ctl",   64'({bus.ex_regwrite, bus.ex_memwrite, bus.ex_aluop}), 64'd0);
      check_val("inv_rd",    64'(bus.ex_rd), 64'd7);

      // async reset between edges clears outputs
      clear_inputs();
      bus.id_valid = 1'b1; bus.rs1 = 5'd2; bus.rd = 5'd8;
      bus.ReadData1 = 64'h55; bus.regwrite_in = 1'b1;
      tick();
      check_val("ar_pre_valid", 64'(bus.ex_valid), 64'd1);
      #3 reset = 1'b0;
      #1;
      check_val("ar_valid",     64'(bus.ex_valid), 64'd0);
      check_val("ar_data1",     bus.ex_data1, 64'd0);
      check_val("ar_rd",        64'(bus.ex_rd), 64'd0);
      check_val("ar_regwrite",  64'(bus.ex_regwrite), 64'd0);
      check_val("ar_flush_cnt", 64'(bus.flush_count), 64'd0);
      check_val("ar_stall_cnt", 64'(bus.stall_count), 64'd0);
      #1 reset = 1'b1;
      tick();
      check_val("ar_reload_valid", 64'(bus.ex_valid), 64'd1);
      check_val("ar_reload_data1", bus.ex_data1, 64'h55);

      // reset asserted while a hazard is pending
      drive_load(5'd10);
      tick();
      clear_inputs();
      bus.id_valid = 1'b1; bus.rs1 = 5'd10; bus.rd = 5'd13;
      bus.ReadData1 = 64'h77;
      #1;
      check_val("rs_stall_on", 64'(bus.stall), 64'd1);
      reset = 1'b0;
      #1;
      check_val("rs_stall_rst", 64'(bus.stall), 64'd0);
      #1 reset = 1'b1;
      tick();
      check_val("rs_load_valid", 64'(bus.ex_valid), 64'd1);
      check_val("rs_load_rd",    64'(bus.ex_rd), 64'd13);
      check_val("rs_load_data1", bus.ex_data1, 64'h77);
      check_val("rs_stall_cnt",  64'(bus.stall_count), 64'd0);

      // flush counter saturation on 4-bit instance
      clear_inputs();
      bus2.flush = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      check_val("sat_14", 64'(bus2.flush_count), 64'd14);
      for (int i = 0; i < 5; i++) tick();
      check_val("sat_hold",  64'(bus2.flush_count), 64'd15);
      check_val("sat_stall", 64'(bus2.stall_count), 64'd0);
      bus2.flush = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 64, width of register operands, immediate and PC.
REQ-002 Parameter: CNT_W, 32, width of stall/flush performance counters.
REQ-003 Port: clock  input  1  single clock, all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 Port: id_valid, rs1, rs2, rd  input  1/5/5/5  decoded instruction valid flag and register indices.
REQ-006 Port: ReadData1, ReadData2  input  DATA_W each  register-file read ports for rs1/rs2.
REQ-007 Port: imm, pc  input  DATA_W each  sign-extended immediate, instruction PC.
REQ-008 Port: regwrite_in, memread_in, memwrite_in, memtoreg_in, alusrc_in, branch_in  input  1 each; aluop_in  input  2  decoded control.
REQ-009 Port: wb_regwrite, wb_rd, wb_data  input  1/5/DATA_W  writeback port values presented to the register file this cycle.
REQ-010 Port: flush  input  1  taken branch/redirect from EX.
REQ-011 Port: ex_valid, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc, ex_* control (same widths as inputs)  output  registered ID/EX contents.
REQ-012 Port: stall  output  1  combinational load-use hazard; holds PC and IF/ID upstream.
REQ-013 Port: stall_count, flush_count  output  CNT_W each  saturating event counters.

Function
REQ-014 Block shall be a single ID/EX pipeline register with hazard detection and WB-to-ID bypass; latency one cycle.
REQ-015 stall shall be 1 iff ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==rs1 | ex_rd==rs2); otherwise 0.
REQ-016 Capture priority each edge: flush > stall > normal load.
REQ-017 flush=1: register loads bubble -- ex_valid=0, all ex_* control bits and aluop=0, indices/data/imm/pc=0.
REQ-018 stall=1 and flush=0: register loads the same bubble as REQ-017; the instruction in ID is not lost (upstream holds it).
REQ-019 Normal load: all ex_* take current inputs; ex_valid=id_valid; when id_valid=0 control bits load as 0.
REQ-020 Bypass: if wb_regwrite & wb_rd!=0 & wb_rd==rs1, ex_data1 captures wb_data instead of ReadData1; same rule for rs2/ex_data2; both may bypass simultaneously.
REQ-021 rs1/rs2 equal to 0 shall never bypass; captured data for x0 is ReadData as presented.
REQ-022 stall_count shall increment by 1 on each edge where stall=1 and flush=0; flush_count on each edge where flush=1.
REQ-023 Counters shall saturate at all-ones and never wrap.
REQ-024 flush and stall asserted together shall count as flush only.
REQ-025 No output shall be driven by an X source when reset has been applied.

Reset
REQ-026 reset=0 shall asynchronously clear every ex_* output, ex_valid, stall_count and flush_count to 0, without waiting for clock.
REQ-027 stall shall evaluate to 0 during and immediately after reset (ex_valid=0).
REQ-028 reset asserted mid-stall shall discard the held hazard; first edge after release performs a normal load.

Verification
REQ-029 Normal flow: id_valid=1, rs1=5, rs2=7, rd=3, ReadData1=5, ReadData2=7, imm=16, regwrite_in=1 -> next edge ex_valid=1, ex_data1=5, ex_data2=7, ex_imm=16, ex_regwrite=1, stall=0.
REQ-030 Load-use: ex holds memread=1, ex_rd=10; ID presents rs2=10 -> stall=1 same cycle; next edge bubble (ex_valid=0), stall_count=1; following edge instruction captured, stall=0.
REQ-031 Bypass: wb_regwrite=1, wb_rd=11, wb_data=19, rs1=rs2=11, ReadData=0 -> ex_data1=ex_data2=19; repeat with wb_rd=0, rs1=0 -> ex_data1=ReadData1.
REQ-032 Flush over stall: hazard active and flush=1 same edge -> bubble, flush_count=1, stall_count unchanged.
REQ-033 Saturation: force 2^CNT_W+3 flush cycles (CNT_W=4 override) -> flush_count holds 15.
REQ-034 Async reset: assert reset=0 between clock edges with ex_valid=1 -> all outputs 0 before next edge; release -> normal load next edge.
